fpm_arbiter: RTL
================

// Module: fpm_arbiter
// PURPOSE
//  Shares one fpmwrapper FP-multiply accelerator among NREQ requesters (round-robin).
//  Per job: writes operands A/B, pulses start, polls status until done, reads product + flags, acks owner.
//  Sits between requester logic and the wrapper's register port (a/wd/we/rd); only master of that port.
// PARAMETERS
//  NREQ        2     number of requesters (1..8)
//  TIMEOUT_CYC 1024  max WAIT cycles before abort (used only with FPM_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  req        in   NREQ     level request per requester; hold with operands until ack
//  req_opa    in   32*NREQ  operand A, requester i at [32*i+:32]
//  req_opb    in   32*NREQ  operand B, same packing
//  ack        out  NREQ     one-cycle pulse to job owner; res_p/res_flags valid that cycle
//  res_p      out  32       product of last job (held until next ACK)
//  res_flags  out  6        {OF,UF,NaN,Inf,DN,Z} = wrapper status[13:8]
//  res_err    out  1        timeout abort flag, valid with ack (tied 0 without macro)
//  busy       out  1        high from grant to ACK inclusive
//  owner      out  clog2(NREQ)  index of current/last granted requester
//  fpm_a      out  2        wrapper address: 0=A, 1=B, 2=product, 3=start/status
//  fpm_wd     out  32       wrapper write data
//  fpm_we     out  1        wrapper write enable
//  fpm_rd     in   32       wrapper read data (combinational from fpm_a)
// BEHAVIOUR
//  Reset (rst=0, any state, async): state=IDLE; ack,res_p,res_flags,res_err,busy,owner,fpm_a,fpm_wd,fpm_we = 0;
//   RR pointer=0. Mid-job reset abandons job, no ack.
//  All outputs registered. fpm_we high only in WR_A/WR_B/WR_GO.
//  FSM:
//   IDLE : any req -> grant first requester at/after RR pointer; latch owner, operands -> WR_A.
//   WR_A : a=0, wd=opa, we=1 -> WR_B.      WR_B : a=1, wd=opb, we=1 -> WR_GO.
//   WR_GO: a=3, wd=32'h1, we=1 (clears wrapper done latch, starts fpmul) -> WAIT.
//   WAIT : a=3, we=0; poll fpm_rd[0]; when 1 capture res_flags<=fpm_rd[13:8] -> RD_P.
//   RD_P : a=2; capture res_p<=fpm_rd -> ACK.
//   ACK  : ack[owner]=1 one cycle, busy=1; RR pointer<=owner+1 (wrap NREQ-1 -> 0) -> IDLE.
//  Min latency grant-to-ack: 6 cycles + fpmul compute cycles in WAIT.
//  req sampled only in IDLE; req still high in cycle after ack = new request, competes normally.
//  Simultaneous reqs: RR order; requester granted at ACK is lowest priority next round.
//  req dropped after grant: job still completes and acks (operands already latched).
//  WAIT polls status bit0, not wrapper syscall pulse: no missed-pulse hazard.
//  Wrapper reset independently mid-job: WAIT stalls (timeout only with macro).
// CONFIGURATION
//  FPM_ARB_TIMEOUT_EN defined: counter in WAIT; at TIMEOUT_CYC cycles without done -> ACK with
//   res_err=1, res_p=0, res_flags=0; no RD_P. Counter cleared on WAIT entry.
//  Undefined: no counter, WAIT unbounded, res_err constant 0.
// TESTING
//  1 req0, A=0x40000000, B=0x40400000 -> bus: a=0,1,3 writes; ack[0] pulse; res_p=0x40C00000, flags=0.
//  2 req0,req1 same cycle, ptr=0 -> ack[0] first, then ack[1]; no overlapping bus writes.
//  3 req1 held high across 3 jobs, req0 pulses once -> grants alternate 1,0,1 (RR fairness).
//  4 A=B=0x7F000000 -> ack, res_flags[5] (OF)=1.
//  5 rst low in WAIT -> all outputs 0 next edge, no ack; new req afterwards completes normally.
//  6 FPM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, done never set -> ack 16 cycles after WAIT entry, res_err=1.

Source files
------------

// File: rtl/fpm_arbiter.sv
// Round-robin arbiter sharing one fpmwrapper FP-multiply accelerator among NREQ requesters.
// Optional WAIT timeout abort enabled by defining FPM_ARB_TIMEOUT_EN.
module fpm_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NREQ-1:0]                         req,
  input  logic [32*NREQ-1:0]                      req_opa,
  input  logic [32*NREQ-1:0]                      req_opb,
  output logic [NREQ-1:0]                         ack,
  output logic [31:0]                             res_p,
  output logic [5:0]                              res_flags,
  output logic                                    res_err,
  output logic                                    busy,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] owner,
  output logic [1:0]                              fpm_a,
  output logic [31:0]                             fpm_wd,
  output logic                                    fpm_we,
  input  logic [31:0]                             fpm_rd
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_WAIT, S_RD_P, S_ACK
  } state_t;

  state_t          state_reg, state_next;
  logic [OW-1:0]   ptr_reg, ptr_next;
  logic [OW-1:0]   owner_next, gnt_idx;
  logic            gnt_found;
  logic [31:0]     opb_reg, opb_next;
  logic [NREQ-1:0] ack_next;
  logic [31:0]     res_p_next, wd_next;
  logic [5:0]      flags_next;
  logic            busy_next, we_next;
  logic [1:0]      a_next;
  int              idx;

  logic [31:0] opa_arr [NREQ];
  logic [31:0] opb_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign opa_arr[gi] = req_opa[32*gi +: 32];
      assign opb_arr[gi] = req_opb[32*gi +: 32];
    end
  endgenerate

`ifdef FPM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  assign res_err = err_reg;
`else
  assign res_err = 1'b0;
`endif

  // First active requester at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = OW'(idx);
      end
    end
  end

  // Every registered output is computed for the state being entered.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner;
    opb_next   = opb_reg;
    ack_next   = '0;
    res_p_next = res_p;
    flags_next = res_flags;
    busy_next  = busy;
    a_next     = fpm_a;
    wd_next    = fpm_wd;
    we_next    = 1'b0;
`ifdef FPM_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        if (gnt_found) begin
          owner_next = gnt_idx;
          opb_next   = opb_arr[gnt_idx];
          busy_next  = 1'b1;
          a_next     = 2'd0;
          wd_next    = opa_arr[gnt_idx];
          we_next    = 1'b1;
          state_next = S_WR_A;
        end
      end
      S_WR_A: begin
        a_next     = 2'd1;
        wd_next    = opb_reg;
        we_next    = 1'b1;
        state_next = S_WR_B;
      end
      S_WR_B: begin
        a_next     = 2'd3;
        wd_next    = 32'h1;
        we_next    = 1'b1;
        state_next = S_WR_GO;
      end
      S_WR_GO: begin
        a_next     = 2'd3;
        state_next = S_WAIT;
`ifdef FPM_ARB_TIMEOUT_EN
        cnt_next   = '0;
`endif
      end
      S_WAIT: begin
        if (fpm_rd[0]) begin
          flags_next = fpm_rd[13:8];
          a_next     = 2'd2;
          state_next = S_RD_P;
        end
`ifdef FPM_ARB_TIMEOUT_EN
        else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          res_p_next      = '0;
          flags_next      = '0;
          err_next        = 1'b1;
          ack_next[owner] = 1'b1;
          state_next      = S_ACK;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      S_RD_P: begin
        res_p_next      = fpm_rd;
        ack_next[owner] = 1'b1;
        state_next      = S_ACK;
`ifdef FPM_ARB_TIMEOUT_EN
        err_next        = 1'b0;
`endif
      end
      S_ACK: begin
        busy_next  = 1'b0;
        ptr_next   = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      opb_reg   <= '0;
      owner     <= '0;
      ack       <= '0;
      res_p     <= '0;
      res_flags <= '0;
      busy      <= 1'b0;
      fpm_a     <= '0;
      fpm_wd    <= '0;
      fpm_we    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      opb_reg   <= opb_next;
      owner     <= owner_next;
      ack       <= ack_next;
      res_p     <= res_p_next;
      res_flags <= flags_next;
      busy      <= busy_next;
      fpm_a     <= a_next;
      fpm_wd    <= wd_next;
      fpm_we    <= we_next;
    end
  end

`ifdef FPM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
`endif

endmodule
